// File: rtl/seq_alu.sv
// Registered, handshaked ALU: single-cycle ops plus an iterative shift-add
// multiplier that returns a full 2*WIDTH-bit product.
module seq_alu #(
    parameter int WIDTH = 16,
    parameter int SHW   = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [5:0]       opcode,
    input  logic [WIDTH-1:0] operand1,
    input  logic [WIDTH-1:0] operand2,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic [WIDTH-1:0] result_hi,
    output logic [4:0]       flags,
    output logic             out_wb,
    output logic             out_illegal
);

    localparam logic [5:0] OP_ADD  = 6'b001001, OP_SUB  = 6'b001010, OP_XOR  = 6'b001011,
                           OP_AND  = 6'b001100, OP_OR   = 6'b001101, OP_CMP  = 6'b001110,
                           OP_MUL  = 6'b001111, OP_ADDI = 6'b010001, OP_SUBI = 6'b010010,
                           OP_XORI = 6'b010011, OP_ANDI = 6'b010100, OP_ORI  = 6'b010101,
                           OP_CMPI = 6'b010110, OP_NEG  = 6'b011000, OP_COM  = 6'b011001,
                           OP_SRL  = 6'b011010, OP_SLL  = 6'b011011, OP_DEC  = 6'b011100,
                           OP_INC  = 6'b011101, OP_ASR  = 6'b011110, OP_CLR  = 6'b011111;

    localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);
    localparam logic [WIDTH-1:0] MIN_NEG = {1'b1, {(WIDTH-1){1'b0}}};
    localparam logic [SHW:0]     LAST    = (SHW+1)'(WIDTH);

    typedef enum logic [1:0] {IDLE, MUL_BUSY, DONE} state_t;

    state_t state, state_nx;

    logic [WIDTH-1:0]   alu_res, addend, subtrahend;
    logic               alu_c, alu_v, alu_wb, alu_ill;
    logic [WIDTH:0]     add_ext, sub_ext, shr_ext, shl_ext;
    logic [SHW-1:0]     sh;

    logic [2*WIDTH-1:0] acc, mcand;
    logic [WIDTH-1:0]   mplier;
    logic [SHW:0]       count;

    logic accept, mul_last;

    function automatic logic [4:0] mk_flags(input logic [WIDTH-1:0] r, input logic c, input logic v);
        return {c, (r == '0), r[WIDTH-1], v, ^r};
    endfunction

    assign accept   = (state == IDLE) && in_valid;
    assign mul_last = (state == MUL_BUSY) && (count == LAST);

    // Single-cycle datapath; C is recovered from one extra bit on each shifter.
    always_comb begin
        // NOTE: every output gets a default first so no path can infer a latch.
        alu_res    = '0;
        alu_c      = 1'b0;
        alu_v      = 1'b0;
        alu_wb     = 1'b1;
        alu_ill    = 1'b0;
        sh         = operand2[SHW-1:0];
        addend     = (opcode == OP_INC) ? ONE : operand2;
        subtrahend = (opcode == OP_DEC) ? ONE : operand2;
        add_ext    = {1'b0, operand1} + {1'b0, addend};
        sub_ext    = {1'b0, operand1} - {1'b0, subtrahend};
        shr_ext    = {operand1, 1'b0} >> sh;
        shl_ext    = {1'b0, operand1} << sh;
        case (opcode)
            OP_ADD, OP_ADDI, OP_INC: begin
                alu_res = add_ext[WIDTH-1:0];
                alu_c   = add_ext[WIDTH];
                alu_v   = (operand1[WIDTH-1] == addend[WIDTH-1]) &&
                          (add_ext[WIDTH-1] != operand1[WIDTH-1]);
            end
            OP_SUB, OP_SUBI, OP_DEC, OP_CMP, OP_CMPI: begin
                alu_res = sub_ext[WIDTH-1:0];
                alu_c   = sub_ext[WIDTH];
                alu_v   = (operand1[WIDTH-1] != subtrahend[WIDTH-1]) &&
                          (sub_ext[WIDTH-1] != operand1[WIDTH-1]);
                alu_wb  = (opcode != OP_CMP) && (opcode != OP_CMPI);
            end
            OP_XOR, OP_XORI: alu_res = operand1 ^ operand2;
            OP_AND, OP_ANDI: alu_res = operand1 & operand2;
            OP_OR,  OP_ORI:  alu_res = operand1 | operand2;
            OP_COM:          alu_res = ~operand1;
            OP_CLR:          alu_res = '0;
            OP_NEG: begin
                alu_res = '0 - operand1;
                alu_c   = (operand1 != '0);
                alu_v   = (operand1 == MIN_NEG);
            end
            OP_SRL: begin
                alu_res = shr_ext[WIDTH:1];
                alu_c   = shr_ext[0];
            end
            OP_ASR: begin
                alu_res = $signed(operand1) >>> sh;
                alu_c   = shr_ext[0];
            end
            OP_SLL: begin
                alu_res = shl_ext[WIDTH-1:0];
                alu_c   = shl_ext[WIDTH];
            end
            OP_MUL: ;
            default: begin
                alu_wb  = 1'b0;
                alu_ill = 1'b1;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= IDLE;
        else     state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        case (state)
            IDLE:     if (in_valid) state_nx = (opcode == OP_MUL) ? MUL_BUSY : DONE;
            MUL_BUSY: if (count == LAST) state_nx = DONE;
            DONE:     if (out_ready) state_nx = IDLE;
            default:  state_nx = IDLE;
        endcase
    end

    always_comb begin
        in_ready  = (state == IDLE);
        out_valid = (state == DONE);
    end

    // One partial product per cycle: bit[count] of the multiplier gates the
    // multiplicand, which is pre-shifted one place each step.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            // NOTE: sequential state uses non-blocking assignments only.
            acc    <= '0;
            mcand  <= '0;
            mplier <= '0;
            count  <= '0;
        end else if (accept && opcode == OP_MUL) begin
            acc    <= '0;
            mcand  <= {{WIDTH{1'b0}}, operand1};
            mplier <= operand2;
            count  <= '0;
        end else if (state == MUL_BUSY && count != LAST) begin
            if (mplier[count[SHW-1:0]]) acc <= acc + mcand;
            mcand <= mcand << 1;
            count <= count + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            result      <= '0;
            result_hi   <= '0;
            flags       <= '0;
            out_wb      <= 1'b0;
            out_illegal <= 1'b0;
        end else if (accept && opcode != OP_MUL) begin
            result      <= alu_res;
            result_hi   <= '0;
            flags       <= alu_ill ? 5'b0 : mk_flags(alu_res, alu_c, alu_v);
            out_wb      <= alu_wb;
            out_illegal <= alu_ill;
        end else if (mul_last) begin
            result      <= acc[WIDTH-1:0];
            result_hi   <= acc[2*WIDTH-1:WIDTH];
            flags       <= mk_flags(acc[WIDTH-1:0], |acc[2*WIDTH-1:WIDTH], |acc[2*WIDTH-1:WIDTH]);
            out_wb      <= 1'b1;
            out_illegal <= 1'b0;
        end
    end

endmodule

// File: tb/tb_seq_alu.sv
// Directed bench for seq_alu (WIDTH=16): ALU vectors, multiplier latency,
// output hold, no-bypass handshake, mid-MUL reset and illegal opcodes.
module tb_seq_alu;

    localparam logic [5:0] OP_ADD  = 6'b001001, OP_SUB  = 6'b001010, OP_XOR  = 6'b001011,
                           OP_AND  = 6'b001100, OP_CMP  = 6'b001110, OP_MUL  = 6'b001111,
                           OP_ADDI = 6'b010001, OP_SUBI = 6'b010010, OP_ANDI = 6'b010100,
                           OP_ORI  = 6'b010101, OP_CMPI = 6'b010110, OP_NEG  = 6'b011000,
                           OP_COM  = 6'b011001, OP_SRL  = 6'b011010, OP_SLL  = 6'b011011,
                           OP_DEC  = 6'b011100, OP_INC  = 6'b011101, OP_ASR  = 6'b011110,
                           OP_CLR  = 6'b011111;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [5:0]  opcode = '0;
    logic [15:0] operand1 = '0;
    logic [15:0] operand2 = '0;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic [15:0] result, result_hi;
    logic [4:0]  flags;
    logic        out_wb, out_illegal;

    int checks = 0;
    int errors = 0;
    bit ready_seen;

    typedef struct packed {
        logic [5:0]  op;
        logic [15:0] a, b, res;
        logic [4:0]  fl;
        logic        wb;
    } vec_t;

    vec_t vecs [0:19];

    seq_alu #(.WIDTH(16)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .opcode(opcode), .operand1(operand1), .operand2(operand2),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .result_hi(result_hi), .flags(flags), .out_wb(out_wb), .out_illegal(out_illegal)
    );

    always #5 clk = ~clk;

    // Present one request, return edges from accept until out_valid is seen.
    task automatic issue(input logic [5:0] op, input logic [15:0] a, input logic [15:0] b,
                         output int lat);
        int budget = 0;
        @(negedge clk);
        while (!in_ready && budget < 50) begin
            @(negedge clk);
            budget++;
        end
        checks++;
        if (!in_ready) begin
            errors++;
            $display("FAIL issue_ready: in_ready=%b required 1", in_ready);
        end
        opcode = op; operand1 = a; operand2 = b; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        ready_seen = 1'b0;
        lat = 0;
        while (!out_valid && lat < 100) begin
            if (in_ready) ready_seen = 1'b1;
            @(posedge clk);
            #1 lat++;
        end
        checks++;
        if (!out_valid) begin
            errors++;
            $display("FAIL out_valid_timeout: out_valid=%b required 1", out_valid);
        end
    endtask

    task automatic drain();
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++;
        if ({in_ready, out_valid, result, result_hi, flags, out_wb, out_illegal} !== {1'b1, 1'b0, 39'd0}) begin
            errors++;
            $display("FAIL reset_state: rdy=%b vld=%b res=%h hi=%h fl=%b wb=%b ill=%b required rdy=1, all else 0",
                     in_ready, out_valid, result, result_hi, flags, out_wb, out_illegal);
        end
        rst = 1'b0;
    endtask

    task automatic test_alu();
        int lat;
        vecs = '{
            '{OP_ADD,  16'h0FFF, 16'h1FF0, 16'h2FEF, 5'b00000, 1'b1},
            '{OP_SUB,  16'h0FFF, 16'h1FF0, 16'hF00F, 5'b10100, 1'b1},
            '{OP_CMP,  16'h0FFF, 16'h1FF0, 16'hF00F, 5'b10100, 1'b0},
            '{OP_CMPI, 16'h0FFF, 16'h1FF0, 16'hF00F, 5'b10100, 1'b0},
            '{OP_ANDI, 16'hF0F0, 16'h0FF0, 16'h00F0, 5'b00000, 1'b1},
            '{OP_ORI,  16'h00F0, 16'h0F00, 16'h0FF0, 5'b00000, 1'b1},
            '{OP_XOR,  16'h0FF0, 16'hFF00, 16'hF0F0, 5'b00100, 1'b1},
            '{OP_NEG,  16'h0001, 16'h0000, 16'hFFFF, 5'b10100, 1'b1},
            '{OP_COM,  16'h00FF, 16'h0000, 16'hFF00, 5'b00100, 1'b1},
            '{OP_INC,  16'hFFFF, 16'h0000, 16'h0000, 5'b11000, 1'b1},
            '{OP_DEC,  16'h8000, 16'h0000, 16'h7FFF, 5'b00011, 1'b1},
            '{OP_CLR,  16'h1234, 16'h5678, 16'h0000, 5'b01000, 1'b1},
            '{OP_ASR,  16'h8FFF, 16'h0004, 16'hF8FF, 5'b10101, 1'b1},
            '{OP_SRL,  16'h8FFF, 16'h0004, 16'h08FF, 5'b10001, 1'b1},
            '{OP_SRL,  16'h8FFF, 16'h0000, 16'h8FFF, 5'b00101, 1'b1},
            '{OP_SLL,  16'h8FFF, 16'h0004, 16'hFFF0, 5'b00100, 1'b1},
            '{OP_ASR,  16'h8FFF, 16'h0010, 16'h8FFF, 5'b00101, 1'b1},
            '{OP_SLL,  16'h0001, 16'h000F, 16'h8000, 5'b00101, 1'b1},
            '{OP_SUBI, 16'h0005, 16'h0005, 16'h0000, 5'b01000, 1'b1},
            '{OP_ADD,  16'h8000, 16'h8000, 16'h0000, 5'b11010, 1'b1}
        };
        for (int i = 0; i < 20; i++) begin
            issue(vecs[i].op, vecs[i].a, vecs[i].b, lat);
            checks++;
            if ({lat, result_hi, result, flags, out_wb, out_illegal} !==
                {32'd0, 16'h0, vecs[i].res, vecs[i].fl, vecs[i].wb, 1'b0}) begin
                errors++;
                $display("FAIL alu_vec%0d op=%b: lat=%0d hi=%h res=%h fl=%b wb=%b ill=%b required lat=0 hi=0000 res=%h fl=%b wb=%b ill=0",
                         i, vecs[i].op, lat, result_hi, result, flags, out_wb, out_illegal,
                         vecs[i].res, vecs[i].fl, vecs[i].wb);
            end
            drain();
        end
    endtask

    task automatic test_mul();
        int lat;
        logic [15:0] ma [3] = '{16'h0FFF, 16'hFFFF, 16'h0003};
        logic [15:0] mb [3] = '{16'h1FF0, 16'hFFFF, 16'h0005};
        logic [31:0] mp [3] = '{32'h01FE_E010, 32'hFFFE_0001, 32'h0000_000F};
        logic [4:0]  mf [3] = '{5'b10110, 5'b10011, 5'b00000};
        for (int i = 0; i < 3; i++) begin
            issue(OP_MUL, ma[i], mb[i], lat);
            checks++;
            if ({ready_seen, lat} !== {1'b0, 32'd17}) begin
                errors++;
                $display("FAIL mul%0d_timing: lat=%0d ready_seen=%b required lat=17 ready_seen=0", i, lat, ready_seen);
            end
            checks++;
            if ({result_hi, result, flags, out_wb, out_illegal} !== {mp[i], mf[i], 1'b1, 1'b0}) begin
                errors++;
                $display("FAIL mul%0d_value: prod=%h fl=%b wb=%b ill=%b required prod=%h fl=%b wb=1 ill=0",
                         i, {result_hi, result}, flags, out_wb, out_illegal, mp[i], mf[i]);
            end
            drain();
        end
    endtask

    task automatic test_hold();
        int lat;
        issue(OP_ADDI, 16'h7FFF, 16'h0001, lat);
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            opcode = OP_CLR; operand1 = 16'h1111; operand2 = 16'h2222; in_valid = 1'b1;
            @(negedge clk);
            checks++;
            if ({out_valid, in_ready, result_hi, result, flags, out_wb} !==
                {1'b1, 1'b0, 16'h0000, 16'h8000, 5'b00111, 1'b1}) begin
                errors++;
                $display("FAIL hold%0d: vld=%b rdy=%b hi=%h res=%h fl=%b wb=%b required vld=1 rdy=0 hi=0000 res=8000 fl=00111 wb=1",
                         i, out_valid, in_ready, result_hi, result, flags, out_wb);
            end
        end
        in_valid = 1'b0;
        drain();
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
    endtask

    // A request presented in the handshake cycle must wait one more edge.
    task automatic test_back_to_back();
        int lat;
        issue(OP_XOR, 16'hAAAA, 16'h5555, lat);
        @(negedge clk);
        out_ready = 1'b1;
        opcode = OP_CLR; operand1 = 16'h1234; operand2 = 16'h0000; in_valid = 1'b1;
        @(posedge clk);
        #1 out_ready = 1'b0;
        checks++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL no_bypass: vld=%b rdy=%b required vld=0 rdy=1", out_valid, in_ready);
        end
        @(posedge clk);
        #1 in_valid = 1'b0;
        checks++;
        if ({out_valid, result, flags, out_wb} !== {1'b1, 16'h0000, 5'b01000, 1'b1}) begin
            errors++;
            $display("FAIL b2b_second: vld=%b res=%h fl=%b wb=%b required vld=1 res=0000 fl=01000 wb=1",
                     out_valid, result, flags, out_wb);
        end
        drain();
    endtask

    task automatic test_reset_mid_mul();
        int lat;
        @(negedge clk);
        opcode = OP_MUL; operand1 = 16'h0FFF; operand2 = 16'h1FF0; in_valid = 1'b1;
        @(posedge clk);
        #1 in_valid = 1'b0;
        repeat (8) @(posedge clk);
        #1 rst = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready, result, result_hi, flags, out_wb, out_illegal} !== {1'b0, 1'b1, 39'd0}) begin
            errors++;
            $display("FAIL reset_mid_mul: vld=%b rdy=%b res=%h hi=%h fl=%b wb=%b ill=%b required rdy=1, all else 0",
                     out_valid, in_ready, result, result_hi, flags, out_wb, out_illegal);
        end
        @(negedge clk);
        rst = 1'b0;
        issue(OP_ADD, 16'h0FFF, 16'h1FF0, lat);
        checks++;
        if ({lat, result_hi, result, flags, out_wb, out_illegal} !== {32'd0, 16'h0, 16'h2FEF, 5'b00000, 1'b1, 1'b0}) begin
            errors++;
            $display("FAIL add_after_reset: lat=%0d hi=%h res=%h fl=%b wb=%b ill=%b required lat=0 hi=0000 res=2FEF fl=00000 wb=1 ill=0",
                     lat, result_hi, result, flags, out_wb, out_illegal);
        end
        drain();
    endtask

    task automatic test_illegal();
        int lat;
        logic [5:0] bad [3] = '{6'b000000, 6'b111111, 6'b010000};
        for (int i = 0; i < 3; i++) begin
            issue(bad[i], 16'hFFFF, 16'h0001, lat);
            checks++;
            if ({lat, result_hi, result, flags, out_wb, out_illegal} !== {32'd0, 16'h0, 16'h0, 5'b00000, 1'b0, 1'b1}) begin
                errors++;
                $display("FAIL illegal_%b: lat=%0d hi=%h res=%h fl=%b wb=%b ill=%b required lat=0 hi=0 res=0 fl=00000 wb=0 ill=1",
                         bad[i], lat, result_hi, result, flags, out_wb, out_illegal);
            end
            drain();
        end
    endtask

    initial begin
        test_reset();
        test_alu();
        test_mul();
        test_hold();
        test_back_to_back();
        test_reset_mid_mul();
        test_illegal();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
